// File: rtl/uart_tx_fifo_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_fifo_if                                                 |
// | Purpose  : Bundles the producer-side write port, FIFO status and the       |
// |            UART transmitter handshake for uart_tx_fifo.                    |
// | Signals  : wr_data/wr_valid/wr_ready  - producer byte enqueue              |
// |            level/overflow/ovf_clr     - occupancy and sticky drop flag     |
// |            uart_din/uart_wr_en        - byte and strobe to transmitter     |
// |            uart_tx_busy               - transmitter busy flag              |
// | Modports : slave  - the FIFO itself                                        |
// |            master - producer plus transmitter side                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface uart_tx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          wr_data;
  logic                wr_valid;
  logic                wr_ready;
  logic [DEPTH_LOG2:0] level;
  logic                overflow;
  logic                ovf_clr;
  logic [7:0]          uart_din;
  logic                uart_wr_en;
  logic                uart_tx_busy;

  modport slave (
    input  wr_data, wr_valid, ovf_clr, uart_tx_busy,
    output wr_ready, level, overflow, uart_din, uart_wr_en
  );

  modport master (
    output wr_data, wr_valid, ovf_clr, uart_tx_busy,
    input  wr_ready, level, overflow, uart_din, uart_wr_en
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_fifo                                                    |
// | Purpose  : Circular transmit FIFO in front of a UART transmitter. Accepts  |
// |            bytes at full clock rate and hands them to the transmitter one  |
// |            at a time, pacing on uart_tx_busy.                              |
// | Ports    : clk_50m - system clock, rising edge                             |
// |            rst     - asynchronous active-high reset                        |
// |            bus     - uart_tx_fifo_if.slave (write port, status, UART side) |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int DEPTH_LOG2   = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  wire logic      clk_50m,
  input  wire logic      rst,
  uart_tx_fifo_if.slave  bus
);

  localparam int                  c_depth      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_full_level = (DEPTH_LOG2 + 1)'(c_depth);
  localparam logic [3:0]          c_timeout    = 4'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  // Storage array: written only, never reset, so it sits in its own block.
  logic [7:0]            mem_q [c_depth];

  logic [DEPTH_LOG2-1:0] wptr_q,     wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q,     rptr_d;
  logic [DEPTH_LOG2:0]   count_q,    count_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            din_q,      din_d;
  logic                  wr_en_q,    wr_en_d;
  logic [3:0]            timer_q,    timer_d;
  state_e                state_q,    state_d;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_drop;
  logic w_pop;

  // Full is judged on the occupancy at the start of the cycle, so a pop in
  // the same cycle never makes room for a push.
  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == c_full_level);
  assign w_push  = bus.wr_valid && !w_full;
  assign w_drop  = bus.wr_valid && w_full;
  // Waiting for busy low in IDLE also covers a transmitter that is still
  // shifting after only this block was reset.
  assign w_pop   = (state_q == ST_IDLE) && !w_empty && !bus.uart_tx_busy;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    din_d      = din_q;
    wr_en_d    = 1'b0;
    timer_d    = timer_q;
    state_d    = state_q;

    if (w_push) begin
      wptr_d = wptr_q + 1'b1;
    end

    if (w_pop) begin
      rptr_d = rptr_q + 1'b1;
      din_d  = mem_q[rptr_q];
    end

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear keeps the flag set.
    if (w_drop) begin
      overflow_d = 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (w_pop) begin
          wr_en_d = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        timer_d = c_timeout;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // If the transmitter never acknowledges the strobe, give up after
        // the timeout and treat the byte as sent.
        if (bus.uart_tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else begin
          timer_d = timer_q - 1'b1;
          if (timer_q == 4'd1) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.uart_tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (w_push) begin
      mem_q[wptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      din_q      <= 8'h00;
      wr_en_q    <= 1'b0;
      timer_q    <= '0;
      state_q    <= ST_IDLE;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      din_q      <= din_d;
      wr_en_q    <= wr_en_d;
      timer_q    <= timer_d;
      state_q    <= state_d;
    end
  end

  assign bus.wr_ready   = !w_full;
  assign bus.level      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.uart_din   = din_q;
  assign bus.uart_wr_en = wr_en_q;

endmodule
`default_nettype wire
